// File: rtl/fetch_prefetch_buffer.sv
// Fetch-side prefetch queue: sequential word reads, PC-tagged FIFO to decode, redirect flush, HALT stop.
// Optional FETCH_BYPASS_EN lets a response reach decode combinationally when the FIFO is empty.
module fetch_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            halted
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_L = (PTR_W + 1)'(DEPTH);

  function automatic logic is_halt(input logic [31:0] w);
    return &w[31:21];
  endfunction

  logic [31:0]     mem_data [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  pc_p1;
  logic             vld_p1;
  logic             halt_seen;

  logic             redir_eff, resp_ok, fifo_empty, byp;
  logic             xfer, pop, push;
  logic [31:0]      head_data;
  logic [PC_W-1:0]  head_pc;
  logic             unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Stage p0: issue request at fetch_pc
  assign redir_eff  = redirect && !halted;
  assign imem_req   = !reset && !redirect && !halt_seen &&
                      ((count + {{PTR_W{1'b0}}, vld_p1}) < DEPTH_L);
  assign imem_addr  = fetch_pc;

  // Stage p1: response arrives, either pushed or (with bypass) handed straight to decode
  assign resp_ok    = vld_p1 && !reset && !redir_eff && !halt_seen;
  assign fifo_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign byp       = resp_ok && fifo_empty;
  assign head_data = fifo_empty ? imem_rdata : mem_data[rd_ptr];
  assign head_pc   = fifo_empty ? pc_p1      : mem_pc[rd_ptr];
`else
  assign byp       = 1'b0;
  assign head_data = mem_data[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];
`endif

  assign inst_valid = !fifo_empty || byp;
  assign inst       = inst_valid ? head_data : '0;
  assign inst_pc    = inst_valid ? head_pc   : '0;

  assign xfer = inst_valid && inst_ready;
  assign pop  = xfer && !fifo_empty;
  assign push = resp_ok && !(byp && inst_ready);

  always_ff @(posedge clk) begin
    if (imem_req) pc_p1 <= fetch_pc;
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= pc_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_pc  <= '0;
      vld_p1    <= 1'b0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (xfer && is_halt(inst)) halted <= 1'b1;
      if (redir_eff) begin
        // A head transfer in this cycle still completes; everything behind it is dropped.
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        fetch_pc  <= {redirect_pc[PC_W-1:2], 2'b00};
        vld_p1    <= 1'b0;
        halt_seen <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
        count  <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        if (resp_ok && is_halt(imem_rdata)) halt_seen <= 1'b1;
        vld_p1 <= imem_req;
        if (imem_req) fetch_pc <= fetch_pc + PC_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized bench for fetch_prefetch_buffer against a queue-based reference model.
module tb_fetch_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            halted;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [63:0] pc;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        q[$];
  logic [63:0] m_pc = '0;
  logic        m_infl = 1'b0;
  logic [63:0] m_infl_pc = '0;
  logic        m_hs = 1'b0;
  logic        m_halted = 1'b0;
  logic        prev_rst = 1'b1;
  logic [63:0] halt_addr = 64'h1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_halt_w(input logic [31:0] w);
    return w[31:21] == 11'h7FF;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    if (a == halt_addr) return 32'hFFE00000 | {11'b0, a[20:0]};
    if (a == 64'h0) return 32'h8B020020;
    if (a == 64'h4) return 32'hCB030041;
    if (a == 64'h8) return 32'hD503201F;
    w = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
    if (w[31:21] == 11'h7FF) w[21] = 1'b0;
    return w;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic rd, input logic [63:0] rpc);
    logic        exp_req, redir_eff, resp_ok, byp, exp_valid, xfer;
    logic [31:0] rw;
    ent_t        head;
    @(negedge clk);
    reset       = rst;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    rw          = m_infl ? mem_word(m_infl_pc) : $urandom;
    imem_rdata  = rw;

    exp_req   = !rst && !rd && !m_hs && ((q.size() + int'(m_infl)) < DEPTH);
    redir_eff = rd && !m_halted;
    resp_ok   = m_infl && !rst && !redir_eff && !m_hs;
    byp       = BYP && resp_ok && (q.size() == 0);
    exp_valid = (q.size() != 0) || byp;
    head      = (q.size() != 0) ? q[0] : '{w: rw, pc: m_infl_pc};
    #1;
    check("imem_req", {63'b0, imem_req}, {63'b0, exp_req});
    check("inst_valid", {63'b0, inst_valid}, {63'b0, exp_valid});
    check("halted", {63'b0, halted}, {63'b0, m_halted});
    if (exp_req || prev_rst) check("imem_addr", imem_addr, m_pc);
    if (exp_valid) begin
      check("inst", {32'b0, inst}, {32'b0, head.w});
      check("inst_pc", inst_pc, head.pc);
    end else if (prev_rst) begin
      check("inst_rst", {32'b0, inst}, 64'h0);
      check("inst_pc_rst", inst_pc, 64'h0);
    end

    xfer = exp_valid && rdy;
    if (rst) begin
      q.delete();
      m_pc = '0; m_infl = 1'b0; m_hs = 1'b0; m_halted = 1'b0;
    end else begin
      if (xfer && is_halt_w(head.w)) m_halted = 1'b1;
      if (redir_eff) begin
        q.delete();
        m_pc   = rpc & ~64'h3;
        m_infl = 1'b0;
        m_hs   = 1'b0;
      end else begin
        if (xfer && q.size() != 0) void'(q.pop_front());
        if (resp_ok && !(byp && xfer)) q.push_back('{w: rw, pc: m_infl_pc});
        if (resp_ok && is_halt_w(rw)) m_hs = 1'b1;
        m_infl = exp_req;
        if (exp_req) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 64'd4;
        end
      end
    end
    prev_rst = rst;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0);
  endtask

  initial begin
    logic [63:0] rpc;
    logic        rd, rst, rdy;
    repeat (2) @(posedge clk);

    // In-order streaming with ready held high
    run(10, 1'b1);

    // Backpressure until full, then drain
    step(1'b1, 1'b0, 1'b0, '0);
    run(8, 1'b0);
    run(8, 1'b1);

    // Redirect with two queued entries and one in flight
    step(1'b1, 1'b0, 1'b0, '0);
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h43);
    run(8, 1'b1);

    // HALT at 0xC with ready high
    halt_addr = 64'hC;
    step(1'b1, 1'b1, 1'b0, '0);
    run(12, 1'b1);
    step(1'b0, 1'b1, 1'b1, 64'h100);
    run(4, 1'b1);

    // Redirect while HALT is queued but not accepted
    step(1'b1, 1'b0, 1'b0, '0);
    run(6, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h20);
    run(8, 1'b1);

    // Reset with a full FIFO and a request in flight
    halt_addr = 64'h1;
    step(1'b1, 1'b0, 1'b0, '0);
    run(6, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    run(5, 1'b1);

    // PC wrap-around at the top of the address space
    step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF5);
    run(8, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 250) == 0;
      rdy = ($urandom % 4) != 0;
      rd  = ($urandom % 18) == 0;
      if (($urandom % 8) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
      else rpc = 64'($urandom % 256);
      if (rst) halt_addr = 64'(($urandom % 48) * 4);
      step(rst, rdy, rd, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_buffer.md
# fetch_prefetch_buffer

Synthesizable fetch-side prefetch queue between the instruction memory and InstructionDecode. Issues sequential word reads from the byte-addressed instruction memory and buffers returned 32-bit instructions with their PC in a small FIFO. Presents the instructions to decode through a valid/ready handshake. Handles taken-branch redirects (PCSrc/BranchAddress) by flushing, and stops fetching once a HALT word (bits [31:21] all ones) has been fetched.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PC_W, 64, PC / byte-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  read request for the word at imem_addr.
- imem_addr  out  PC_W  word-aligned byte address; bits [1:0] are always 0.
- imem_rdata  in  32  {IMem[a+3],IMem[a+2],IMem[a+1],IMem[a]}; valid exactly one cycle after the request.
- redirect  in  1  PCSrc: taken branch, one-cycle pulse.
- redirect_pc  in  PC_W  BranchAddress; bits [1:0] ignored and treated as 0.
- inst_valid  out  1  inst/inst_pc are valid.
- inst_ready  in  1  decode accepts; a transfer occurs when valid && ready.
- inst  out  32  instruction word.
- inst_pc  out  PC_W  byte address of inst.
- halted  out  1  sticky; HALT word has been accepted by decode.

## Operation
- Reset values: fetch_pc=0, FIFO empty, inflight=0, halt_seen=0. Outputs: imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
- Issue condition: imem_req=1 when !reset && !redirect && !halt_seen && (count + inflight) < DEPTH.
  - count excludes any pop in the same cycle.
  - On issue: imem_addr=fetch_pc and fetch_pc += 4. fetch_pc wraps modulo 2^PC_W.
- Response: a response tagged valid the cycle after issue is pushed with pc=issued address, unless it is squashed.
- Pop: on inst_valid && inst_ready, the head entry is removed. Push and pop may occur in the same cycle; FIFO order is strict.
- Redirect (priority over push/issue):
  - A transfer occurring in the redirect cycle still completes.
  - All remaining entries are flushed and any response due next cycle is squashed.
  - fetch_pc=redirect_pc; no request is issued in the redirect cycle.
  - halt_seen is cleared unless halted=1.
- HALT:
  - A pushed word with inst[31:21]==11'h7FF sets halt_seen. The response arriving the following cycle is squashed and no further requests are issued.
  - halted rises the cycle after the HALT entry transfers, and stays high until reset. Once halted=1, redirect is ignored.
- Reset mid-operation: all state returns to reset values the next cycle; any outstanding response is discarded.

## Timing
- Without bypass: request at cycle t, data at t+1, inst_valid at t+2.
- First request is issued in the first cycle reset is low, at addr 0.
- Sustained throughput is 1 instruction/cycle when inst_ready is held high.
- Redirect at cycle t: request for redirect_pc at t+1; inst_valid for it at t+3 (t+2 with bypass). inst_valid=0 from t+1 until then.
- Full: imem_req deasserts once count+inflight==DEPTH, and reasserts the cycle after a pop.
- halted asserts exactly 1 cycle after the HALT transfer.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a non-squashed response arrives, it drives inst/inst_pc combinationally with inst_valid=1 in the same cycle.
  - If accepted, it is not pushed; otherwise it is pushed.
  - Latency from request to inst_valid drops to 1 cycle.
- FETCH_BYPASS_EN undefined: all instructions pass through the FIFO registers; latency is 2 cycles; no combinational path from imem_rdata to the outputs.

## Test plan
- Reset, IMem words 0x8B020020@0, 0xCB030041@4, 0xD503201F@8, inst_ready=1 -> imem_addr 0,4,8 on cycles 0,1,2; inst=0x8B020020/pc 0 on cycle 2, then one word per cycle in order.
- inst_ready=0, DEPTH=4 -> exactly 4 requests (0x0–0xC), then imem_req=0; inst holds pc 0. Raise ready -> pcs 0,4,8,C drained in order; fetching resumes at 0x10.
- Redirect redirect_pc=0x43 while 2 entries are queued and 1 request is in flight -> next cycle inst_valid=0, imem_addr=0x40; first inst_pc after the flush is 0x40; no stale pc is delivered.
- 0xFFE00000 at 0xC, ready=1 -> no request beyond addr 0x10; the 0x10 response is dropped; halted=1 the cycle after pc 0xC transfers; imem_req stays 0.
- Redirect to 0x20 while the HALT word is queued but not accepted -> halt_seen cleared, fetching resumes at 0x20, halted stays 0.
- Reset asserted with a full FIFO and a request in flight -> next cycle all outputs are at reset values; after release, the first inst_pc is 0 (cycle 2, or cycle 1 with FETCH_BYPASS_EN).
